// File: rtl/mpmc11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_pkg
// Purpose  : Shared types and constants for the mpmc11 controller slice:
//            controller state encoding, timeout-responder state encoding,
//            and the timeout bit position.
// Revision : 1.0 - initial release
// ============================================================================
package mpmc11_pkg;

  // Main controller state machine encoding.
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    ACTIVATE    = 4'd1,
    READ_CMD    = 4'd2,
    READ_DATA   = 4'd3,
    WRITE_CMD   = 4'd4,
    WRITE_DATA0 = 4'd5,
    WRITE_DATA1 = 4'd6,
    PRECHARGE   = 4'd7,
    REFRESH     = 4'd8
  } mpmc11_state_t;

  // Timeout responder state machine encoding.
  typedef enum logic [2:0] {
    TO_MON    = 3'd0,
    TO_ABORT  = 3'd1,
    TO_DRAIN  = 3'd2,
    TO_REPORT = 3'd3,
    TO_HOLD   = 3'd4
  } mpmc11_to_state_t;

  // Bit of the 16-bit timeout count that flags a timeout (512 cycles).
  localparam int MPMC11_TO_BIT   = 9;
  localparam int MPMC11_TO_CNT_W = 16;

  // One-hot mask selecting the timeout bit of the count.
  function automatic logic [MPMC11_TO_CNT_W-1:0] to_mask(input int bit_idx);
    return MPMC11_TO_CNT_W'(1) << bit_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpmc11_to_recover_if.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_to_recover_if
// Purpose  : Bundle between the timeout responder, the controller FSM,
//            the timeout counter and the channel arbiter.
//            master = responder side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface mpmc11_to_recover_if;
  import mpmc11_pkg::*;

  mpmc11_state_t state;
  mpmc11_state_t prev_state;
  logic [15:0]   to_cnt;
  logic [3:0]    cur_ch;
  logic          force_idle;
  logic          busy;
  logic          err_valid;
  logic          err_ack;
  logic [3:0]    err_ch;
  mpmc11_state_t err_state;
  logic          fatal;
  logic [7:0]    to_events;

  modport master (
    input  state, prev_state, to_cnt, cur_ch, err_ack,
    output force_idle, busy, err_valid, err_ch, err_state, fatal, to_events
  );

  modport slave (
    output state, prev_state, to_cnt, cur_ch, err_ack,
    input  force_idle, busy, err_valid, err_ch, err_state, fatal, to_events
  );

endinterface
`default_nettype wire

// File: rtl/mpmc11_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_sat_cnt
// Purpose  : Generic up-counter with synchronous clear that sticks at MAX.
//            Clear has priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
module mpmc11_sat_cnt #(
  parameter int WIDTH = 8,
  parameter int MAX   = (1 << WIDTH) - 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic      [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Count up on inc, hold at MAX, return to zero on clr or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpmc11_to_recover.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_to_recover
// Purpose  : Timeout responder for the mpmc11 controller. Spots a controller
//            state that has stalled, pulses force_idle, waits for IDLE (or
//            flags fatal), reports channel/state to the arbiter and then
//            holds off before re-arming.
// Revision : 1.0 - initial release
// ============================================================================
module mpmc11_to_recover
  import mpmc11_pkg::*;
#(
  parameter int TO_BIT    = MPMC11_TO_BIT,
  parameter int DRAIN_MAX = 64,
  parameter int HOLDOFF   = 16
) (
  input wire logic             clk,
  input wire logic             rst,
  mpmc11_to_recover_if.master  bus
);

  localparam int DRAIN_W = $clog2(DRAIN_MAX) + 1;
  localparam int HOLD_W  = $clog2(HOLDOFF) + 1;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF - 1);
  localparam logic [15:0]        TO_MASK    = to_mask(TO_BIT);

  mpmc11_to_state_t   fsm;
  mpmc11_to_state_t   fsm_next;

  logic               timeout;
  logic               latch_err;
  logic               event_inc;
  logic               drain_clr;
  logic               drain_inc;
  logic               fatal_set;
  logic               hold_clr;
  logic               hold_inc;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [HOLD_W-1:0]  hold_cnt;

  // Stall: the timeout bit is up while the controller sits in one non-IDLE state.
  assign timeout = ((bus.to_cnt & TO_MASK) != '0) &&
                   (bus.state != IDLE) &&
                   (bus.state == bus.prev_state);

  // Responder state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= TO_MON;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Next-state and counter/latch control.
  always_comb begin
    fsm_next  = fsm;
    latch_err = 1'b0;
    event_inc = 1'b0;
    drain_clr = 1'b0;
    drain_inc = 1'b0;
    fatal_set = 1'b0;
    hold_clr  = 1'b0;
    hold_inc  = 1'b0;
    case (fsm)
      TO_MON: begin
        if (timeout) begin
          latch_err = 1'b1;
          event_inc = 1'b1;
          fsm_next  = TO_ABORT;
        end
      end
      TO_ABORT: begin
        drain_clr = 1'b1;
        fsm_next  = TO_DRAIN;
      end
      TO_DRAIN: begin
        if (bus.state == IDLE) begin
          fsm_next = TO_REPORT;
        end else if (drain_cnt == DRAIN_LAST) begin
          // Controller never came back; still report so the arbiter learns the channel.
          fatal_set = 1'b1;
          fsm_next  = TO_REPORT;
        end else begin
          drain_inc = 1'b1;
        end
      end
      TO_REPORT: begin
        if (bus.err_valid && bus.err_ack) begin
          hold_clr = 1'b1;
          fsm_next = TO_HOLD;
        end
      end
      TO_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          fsm_next = TO_MON;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: begin
        fsm_next = TO_MON;
      end
    endcase
  end

  // Registered handshake/control outputs, decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.force_idle <= 1'b0;
      bus.busy       <= 1'b0;
      bus.err_valid  <= 1'b0;
    end else begin
      bus.force_idle <= (fsm_next == TO_ABORT);
      bus.busy       <= (fsm_next != TO_MON);
      bus.err_valid  <= (fsm_next == TO_REPORT);
    end
  end

  // Capture the failing channel/state at detection; held until the next detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err_ch    <= 4'd0;
      bus.err_state <= IDLE;
    end else if (latch_err) begin
      bus.err_ch    <= bus.cur_ch;
      bus.err_state <= bus.state;
    end
  end

  // Sticky fatal flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fatal <= 1'b0;
    end else if (fatal_set) begin
      bus.fatal <= 1'b1;
    end
  end

  mpmc11_sat_cnt #(
    .WIDTH (8),
    .MAX   (255)
  ) u_event_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (event_inc),
    .count (bus.to_events)
  );

  mpmc11_sat_cnt #(
    .WIDTH (DRAIN_W),
    .MAX   (DRAIN_MAX - 1)
  ) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (drain_clr),
    .inc   (drain_inc),
    .count (drain_cnt)
  );

  mpmc11_sat_cnt #(
    .WIDTH (HOLD_W),
    .MAX   (HOLDOFF - 1)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (hold_clr),
    .inc   (hold_inc),
    .count (hold_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_mpmc11_to_recover.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpmc11_to_recover
// Purpose  : Self-checking bench for mpmc11_to_recover. Each recovery is
//            scripted cycle by cycle; expected outputs come from the
//            behavioural timing rules and a small event/fatal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpmc11_to_recover;
  import mpmc11_pkg::*;

  localparam int DRAIN_MAX = 64;
  localparam int HOLDOFF   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int n_events  = 0;
  bit exp_fatal = 1'b0;

  mpmc11_to_recover_if bus ();

  mpmc11_to_recover #(
    .TO_BIT    (9),
    .DRAIN_MAX (DRAIN_MAX),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_events();
    return 32'((n_events > 255) ? 255 : n_events);
  endfunction

  function automatic mpmc11_state_t rand_busy_state();
    logic [3:0] v;
    v = 4'($urandom_range(1, 8));
    return mpmc11_state_t'(v);
  endfunction

  task automatic quiet_inputs();
    bus.state      = IDLE;
    bus.prev_state = IDLE;
    bus.to_cnt     = 16'h0000;
    bus.err_ack    = 1'b0;
  endtask

  // Apply inputs for n cycles and require that nothing happens.
  task automatic no_action(input string tag, input int n, input logic [15:0] cnt,
                           input mpmc11_state_t st, input mpmc11_state_t pst);
    bus.to_cnt     = cnt;
    bus.state      = st;
    bus.prev_state = pst;
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_force_idle"}, 32'(bus.force_idle), 32'd0);
      chk({tag, "_busy"},       32'(bus.busy),       32'd0);
      chk({tag, "_to_events"},  32'(bus.to_events),  exp_events());
    end
    quiet_inputs();
  endtask

  // One full timeout/recovery sequence.
  // k    : DRAIN cycles spent non-IDLE before IDLE is driven (>=64 means never)
  // w    : cycles err_ack is withheld in REPORT
  // poke : inject ignored timeout conditions and stray acks along the way
  task automatic recover(input logic [3:0] ch, input mpmc11_state_t st,
                         input int k, input int w, input bit poke);
    int nd;
    bus.cur_ch     = ch;
    bus.state      = st;
    bus.prev_state = st;
    bus.to_cnt     = 16'h0200;
    n_events++;
    tick();
    chk("abort_force_idle", 32'(bus.force_idle), 32'd1);
    chk("abort_busy",       32'(bus.busy),       32'd1);
    chk("abort_to_events",  32'(bus.to_events),  exp_events());
    // Timeout counter clears itself; channel moves on
    bus.to_cnt = 16'h0000;
    bus.cur_ch = ~ch;
    tick();
    chk("drain_force_idle", 32'(bus.force_idle), 32'd0);
    chk("drain_busy",       32'(bus.busy),       32'd1);
    nd = (k < DRAIN_MAX) ? k : DRAIN_MAX;
    bus.err_ack = poke;
    for (int i = 1; i <= nd; i++) begin
      tick();
      chk("drain_err_valid", 32'(bus.err_valid), 32'(i == DRAIN_MAX));
      if (i == DRAIN_MAX - 1) bus.err_ack = 1'b0;
    end
    bus.err_ack = 1'b0;
    if (k < DRAIN_MAX) begin
      bus.state      = IDLE;
      bus.prev_state = IDLE;
      tick();
    end else begin
      exp_fatal = 1'b1;
    end
    chk("report_err_valid", 32'(bus.err_valid), 32'd1);
    chk("report_err_ch",    32'(bus.err_ch),    32'(ch));
    chk("report_err_state", 32'(bus.err_state), 32'(st));
    chk("report_fatal",     32'(bus.fatal),     32'(exp_fatal));
    chk("report_busy",      32'(bus.busy),      32'd1);
    for (int j = 0; j < w; j++) begin
      if (poke) begin
        bus.to_cnt     = 16'h0200;
        bus.state      = rand_busy_state();
        bus.prev_state = bus.state;
      end
      tick();
      chk("hold_err_valid",  32'(bus.err_valid),  32'd1);
      chk("hold_err_ch",     32'(bus.err_ch),     32'(ch));
      chk("hold_err_state",  32'(bus.err_state),  32'(st));
      chk("hold_force_idle", 32'(bus.force_idle), 32'd0);
    end
    bus.to_cnt  = 16'h0000;
    bus.err_ack = 1'b1;
    tick();
    bus.err_ack = 1'b0;
    chk("ack_err_valid",  32'(bus.err_valid),  32'd0);
    chk("ack_busy",       32'(bus.busy),       32'd1);
    for (int j = 1; j < HOLDOFF; j++) begin
      if (poke && j < 4) begin
        bus.to_cnt     = 16'h0200;
        bus.state      = st;
        bus.prev_state = st;
      end else begin
        quiet_inputs();
      end
      tick();
      chk("holdoff_busy",       32'(bus.busy),       32'd1);
      chk("holdoff_force_idle", 32'(bus.force_idle), 32'd0);
      chk("holdoff_to_events",  32'(bus.to_events),  exp_events());
    end
    quiet_inputs();
    tick();
    chk("rearm_busy",   32'(bus.busy),      32'd0);
    chk("rearm_fatal",  32'(bus.fatal),     32'(exp_fatal));
    chk("rearm_events", 32'(bus.to_events), exp_events());
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_force_idle"}, 32'(bus.force_idle), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_err_valid"},  32'(bus.err_valid),  32'd0);
    chk({tag, "_err_ch"},     32'(bus.err_ch),     32'd0);
    chk({tag, "_err_state"},  32'(bus.err_state),  32'(IDLE));
    chk({tag, "_fatal"},      32'(bus.fatal),      32'd0);
    chk({tag, "_to_events"},  32'(bus.to_events),  32'd0);
  endtask

  initial begin
    quiet_inputs();
    bus.cur_ch = 4'd0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_cleared("reset");
    #3 rst = 1'b0;
    tick();
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    // Normal recovery: WRITE_DATA0 on channel 5, IDLE after 3 drain cycles
    recover(4'd5, WRITE_DATA0, 3, 0, 1'b0);

    // Handshake hold: ack withheld for 20 cycles
    recover(4'd9, READ_DATA, 1, 20, 1'b0);

    // Ignored events
    no_action("idle_state",   4, 16'h0200, IDLE, IDLE);
    no_action("state_change", 4, 16'h0200, READ_CMD, WRITE_CMD);
    no_action("below_bit",    4, 16'h01FF, REFRESH, REFRESH);

    // Drain boundary: IDLE on the last allowed cycle is not fatal
    recover(4'd3, PRECHARGE, DRAIN_MAX - 1, 2, 1'b1);

    // Randomized recoveries with stray timeouts/acks
    for (int r = 0; r < 12; r++) begin
      recover(4'($urandom_range(0, 15)), rand_busy_state(),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)));
    end

    // Fatal: controller never returns to IDLE
    recover(4'd12, WRITE_DATA1, 200, 3, 1'b0);
    // Fatal stays set across a later clean recovery
    recover(4'd7, ACTIVATE, 2, 0, 1'b1);

    // Reset mid-operation, while a report is pending
    bus.cur_ch     = 4'd10;
    bus.state      = REFRESH;
    bus.prev_state = REFRESH;
    bus.to_cnt     = 16'h0200;
    tick();
    quiet_inputs();
    tick();
    tick();
    chk("midop_err_valid", 32'(bus.err_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_cleared("midop_reset");
    #3 rst = 1'b0;
    n_events  = 0;
    exp_fatal = 1'b0;
    tick();
    chk("midop_rearm_busy", 32'(bus.busy), 32'd0);

    // Saturation: 300 recoveries
    for (int r = 0; r < 300; r++) begin
      recover(4'($urandom_range(0, 15)), rand_busy_state(),
              int'($urandom_range(0, 3)), 0, 1'b0);
    end
    chk("saturated_events", 32'(bus.to_events), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
